// File: rtl/serial_bit_source.sv
// rtl/serial_bit_source.sv - FIFO-buffered word serializer, MSB first, back-to-back words
// Out_bit is the MSB of a shift register that drains to zero, so it is 0 whenever out_valid is low.
module serial_bit_source #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_bit,
  output logic                     out_valid,
  output logic                     word_start,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    bit_idx;
  logic             push, pop;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign out_bit  = shreg[WIDTH-1];

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_idx == '0) begin
          if (count != '0) pop = 1'b1;
          else next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Storage carries no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      out_valid  <= 1'b0;
      word_start <= 1'b0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pop) begin
        shreg      <= mem[rd_ptr];
        bit_idx    <= IW'(WIDTH - 1);
        out_valid  <= 1'b1;
        word_start <= 1'b1;
      end else if (state == SHIFT) begin
        // The final shift of a word empties the register, leaving out_bit at 0.
        shreg      <= {shreg[WIDTH-2:0], 1'b0};
        word_start <= 1'b0;
        if (bit_idx != '0) begin
          bit_idx <= bit_idx - IW'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        word_start <= 1'b0;
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// tb/tb_serial_bit_source.sv - directed self-checking bench for serial_bit_source
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic [7:0] in_data = 8'hAA;
  logic       in_ready, out_bit, out_valid, word_start;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k0;
  int peak;
  logic ready_at_peak;
  logic [7:0] dec_vec;
  logic [3:0] hist;

  logic mb[$];
  logic ms[$];
  int   mc[$];

  serial_bit_source #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
    .word_start(word_start), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (out_valid) begin
      mb.push_back(out_bit);
      ms.push_back(word_start);
      mc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    mb.delete();
    ms.delete();
    mc.delete();
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (mb.size() < n && k < budget) begin
      step();
      k++;
    end
    if (mb.size() < n) check("wait_timeout", 64'(mb.size()), 64'(n));
    repeat (3) step();
  endtask

  task automatic check_stream(input string tag, input int n,
                              input logic [63:0] exp_bits, input logic [63:0] exp_starts);
    logic [63:0] ob = '0;
    logic [63:0] os = '0;
    int gaps = 0;
    check({tag, "_len"}, 64'(mb.size()), 64'(n));
    for (int i = 0; i < mb.size() && i < 64; i++) begin
      ob = {ob[62:0], mb[i]};
      os = {os[62:0], ms[i]};
      if (i > 0 && mc[i] != mc[i-1] + 1) gaps++;
    end
    check({tag, "_bits"}, ob, exp_bits);
    check({tag, "_starts"}, os, exp_starts);
    check({tag, "_gaps"}, 64'(gaps), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held two cycles with in_valid high
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bit", 64'(out_bit), 64'd0);
    check("rst_word_start", 64'(word_start), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_mon_empty", 64'(mb.size()), 64'd0);

    // single word with two-edge latency
    clear_mon();
    push_word(8'b0111_0110);
    k0 = cyc;
    check("single_count_after_push", 64'(count), 64'd1);
    check("single_latency_valid", 64'(out_valid), 64'd0);
    wait_bits(8, 20);
    check_stream("single", 8, 64'h76, 64'h80);
    if (mc.size() > 0) check("single_first_cycle", 64'(mc[0]), 64'(k0 + 1));
    check("single_end_valid", 64'(out_valid), 64'd0);
    check("single_end_bit", 64'(out_bit), 64'd0);
    check("single_end_count", 64'(count), 64'd0);

    // back-to-back words; second push coincides with the first pop
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'hB4;
    step();
    in_data  = 8'h2D;
    step();
    in_valid = 1'b0;
    check("b2b_count_push_pop", 64'(count), 64'd1);
    wait_bits(16, 40);
    check_stream("b2b", 16, 64'hB42D, 64'h8080);

    // full FIFO: words 06..08 are refused
    clear_mon();
    peak = 0;
    ready_at_peak = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      step();
      if (int'(count) > peak) peak = int'(count);
      if (count == 3'd4) ready_at_peak = in_ready;
    end
    in_valid = 1'b0;
    check("full_peak", 64'(peak), 64'd4);
    check("full_ready_low", 64'(ready_at_peak), 64'd0);
    check("full_count_end", 64'(count), 64'd4);
    wait_bits(40, 100);
    check_stream("full", 40, 64'h01_02_03_04_05, 64'h80_80_80_80_80);

    // reset mid-word at bit 3 with two words queued
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_data  = 8'h3C;
    step();
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    step();
    check("midrst_queued", 64'(count), 64'd2);
    check("midrst_busy", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_bit", 64'(out_bit), 64'd0);
    check("midrst_word_start", 64'(word_start), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    clear_mon();
    push_word(8'hFF);
    k0 = cyc;
    wait_bits(8, 20);
    check_stream("after_rst", 8, 64'hFF, 64'h80);
    if (mc.size() > 0) check("after_rst_first_cycle", 64'(mc[0]), 64'(k0 + 1));

    // stream feeding a 0110 overlapping Mealy detector reference
    clear_mon();
    push_word(8'b0111_0110);
    wait_bits(8, 20);
    hist = 4'b1111;
    dec_vec = '0;
    for (int i = 0; i < mb.size() && i < 8; i++) begin
      hist = {hist[2:0], mb[i]};
      dec_vec = {dec_vec[6:0], (hist == 4'b0110)};
    end
    check("detector_dec", 64'(dec_vec), 64'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
